apb_sram_ctrl: RTL and testbench
================================

Name: apb_sram_ctrl

Overview:
- APB4 slave front-end for the 16x32 single-port SRAM macro. It sits directly upstream of that macro: it converts APB transfers into SRAM chip-select, write, address and data strobes, and returns the SRAM read data on PRDATA.
- Full-word reads and writes complete with zero wait states.
- Partial (PSTRB) writes are done as an internal read-modify-write with one wait state.
- Out-of-range or misaligned addresses return PSLVERR and never touch the SRAM.

Parameters:
- P_AW, 8, APB byte-address width. The valid window is 0x00–0x3C, word aligned.
- P_MAW, 4, SRAM word-address width (16 words).

Ports:
- iClk  in  1  rising-edge clock
- iRsn  in  1  asynchronous active-low reset
- iPsel  in  1  APB select
- iPenable  in  1  APB enable
- iPwrite  in  1  1 = write, 0 = read
- iPaddr  in  P_AW  APB byte address
- iPwdata  in  32  APB write data
- iPstrb  in  4  byte strobes; bit n covers byte n
- oPrdata  out  32  APB read data
- oPready  out  1  transfer complete
- oPslverr  out  1  transfer error
- oCsn  out  1  SRAM chip select, active low
- oWrn  out  1  SRAM 0 = write, 1 = read
- oAddr  out  P_MAW  SRAM word address
- oWrDt  out  32  SRAM write data
- iRdDt  in  32  SRAM read data, valid one cycle after a read strobe

Behaviour:
- Clock and reset: one clock, iClk. Reset iRsn is asynchronous and active-low.
- While iRsn is low:
  - state is IDLE and all capture registers are 0.
  - Outputs are forced: oCsn=1, oWrn=1, oAddr=0, oWrDt=0, oPready=0, oPslverr=0, oPrdata=0.
- Setup phase: iPsel=1 and iPenable=0 while the FSM is in IDLE.
- Valid address: iPaddr[1:0]==0 and iPaddr[P_AW-1:6]==0. The word index is iPaddr[5:2].
- On every setup phase, capture the index, iPstrb, iPwdata, iPwrite and an "is read" flag.
- FSM states: IDLE, ACCESS, MERGE, ERROR.
- IDLE, classified in the setup cycle. SRAM outputs in this state are combinational from the APB inputs.
  - Bad address: no SRAM strobe; go to ERROR.
  - Read: oCsn=0, oWrn=1, oAddr=index; go to ACCESS.
  - Write with iPstrb=4'hF: oCsn=0, oWrn=0, oWrDt=iPwdata; go to ACCESS.
  - Write with iPstrb=4'h0: no SRAM strobe; go to ACCESS. This is a no-op write that completes OKAY.
  - Write with any other strobe pattern: read strobe (oCsn=0, oWrn=1); go to MERGE.
  - No setup phase: oCsn=1; stay in IDLE.
- MERGE (first access cycle of an RMW):
  - oPready=0.
  - If iPsel & iPenable: oCsn=0, oWrn=0, oAddr=captured index, and oWrDt built per byte n as captured strb[n] ? captured wdata byte n : iRdDt byte n. Go to ACCESS.
  - Otherwise (protocol abort): no strobe; go to IDLE.
- ACCESS:
  - oPready=1, oPslverr=0.
  - oPrdata=iRdDt for a read, 0 for a write.
  - Go to IDLE.
- ERROR: oPready=1, oPslverr=1, oPrdata=0; go to IDLE.
- Abort in ACCESS or ERROR: if iPsel drops, still go to IDLE. No SRAM write is ever issued outside IDLE or MERGE.
- oPready is low in IDLE.
- Latency, counted from the setup cycle:
  - read, full write, null write and error: 2 cycles (zero wait states).
  - partial write: 3 cycles (one wait state).
- Back-to-back transfers: a new setup phase is accepted in the cycle immediately after the ACCESS or ERROR cycle.
- The SRAM is strobed at most once per cycle. The read-then-write of an RMW sits in consecutive cycles on the same address.
- Asynchronous reset in MERGE cancels the pending write. The SRAM sees oCsn=1 from the reset edge onward.

Decomposition:
- Shared package apb_sram_pkg holds:
  - the state enum (IDLE/ACCESS/MERGE/ERROR)
  - localparam WORD_BYTES=4
  - the valid-window mask
- One natural sub-module, apb_byte_merge: a combinational 32-bit merge of new and old data under a 4-bit strobe. It is reusable by other bus slaves.

Test Plan:
- Reset, then full write 0x14 ← 0xDEADBEEF (strb F), then read 0x14 → oPrdata=0xDEADBEEF. Both transfers take 2 cycles, oPslverr=0, and exactly one SRAM write strobe at word 5.
- Partial write after word 5 = 0xDEADBEEF: write 0x14 ← 0x11223344 with strb 4'b0101. Expect 3 cycles (one oPready=0 wait); a subsequent read returns 0xDE22BE44.
- Error: read 0x40, and write 0x06 (misaligned). Each gives oPready=1 and oPslverr=1 in the first access cycle. oCsn stays 1 throughout, and memory is unchanged.
- Null write: write 0x00 ← 0xFFFFFFFF with strb 0. Completes OKAY in 2 cycles with no SRAM strobe; reading 0x00 returns 0x00000000.
- Back-to-back: write 0x3C ← 0xA5A5A5A5 immediately followed by a read of 0x3C with no idle cycle. The read returns 0xA5A5A5A5.
- Reset mid-RMW: assert iRsn=0 during the MERGE cycle. oCsn rises immediately, no write occurs, the FSM is in IDLE after release, and all outputs sit at their reset values.

Source files
------------

// File: rtl/apb_sram_pkg.sv
// Shared types and constants for the APB front-end of the 16x32 SRAM macro.
package apb_sram_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, ERROR} stateT;

  localparam int WORD_BYTES = 4;

  // Byte-address bits that may be set inside the 0x00-0x3C window.
  localparam logic [5:0] WINDOW_MASK = 6'b11_1100;

endpackage

// File: rtl/apb_byte_merge.sv
// Byte-lane merge of new data over old data under a strobe mask.
module apb_byte_merge
  import apb_sram_pkg::*;
(
  input  logic [WORD_BYTES*8-1:0] iNewDt,
  input  logic [WORD_BYTES*8-1:0] iOldDt,
  input  logic [WORD_BYTES-1:0]   iStrb,
  output logic [WORD_BYTES*8-1:0] oMergedDt
);

  always_comb begin
    oMergedDt = iOldDt;
    for (int n = 0; n < WORD_BYTES; n++) begin
      if (iStrb[n]) oMergedDt[8*n +: 8] = iNewDt[8*n +: 8];
    end
  end

endmodule

// File: rtl/apb_sram_ctrl.sv
// APB4 slave that drives the 16x32 single-port SRAM; partial writes are done
// as a read-modify-write with one wait state.
module apb_sram_ctrl
  import apb_sram_pkg::*;
#(
  parameter int P_AW  = 8,
  parameter int P_MAW = 4
) (
  input  logic             iClk,
  input  logic             iRsn,
  input  logic             iPsel,
  input  logic             iPenable,
  input  logic             iPwrite,
  input  logic [P_AW-1:0]  iPaddr,
  input  logic [31:0]      iPwdata,
  input  logic [3:0]       iPstrb,
  output logic [31:0]      oPrdata,
  output logic             oPready,
  output logic             oPslverr,
  output logic             oCsn,
  output logic             oWrn,
  output logic [P_MAW-1:0] oAddr,
  output logic [31:0]      oWrDt,
  input  logic [31:0]      iRdDt
);

  localparam logic [P_AW-1:0] BAD_BITS = ~P_AW'(WINDOW_MASK);

  stateT state, nextState;

  logic [P_MAW-1:0] idxQ;
  logic [3:0]       strbQ;
  logic [31:0]      wdataQ;
  logic             writeQ;
  logic             isReadQ;

  logic             setupPhase;
  logic             addrOk;
  logic             fullStrb;
  logic             nullStrb;
  logic [P_MAW-1:0] index;
  logic [31:0]      mergedDt;

  assign setupPhase = iPsel & ~iPenable & (state == IDLE);
  assign addrOk     = (iPaddr & BAD_BITS) == '0;
  assign index      = iPaddr[P_MAW+1:2];
  assign fullStrb   = &iPstrb;
  assign nullStrb   = ~|iPstrb;

  apb_byte_merge uMerge (
    .iNewDt    (wdataQ),
    .iOldDt    (iRdDt),
    .iStrb     (strbQ),
    .oMergedDt (mergedDt)
  );

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      idxQ    <= '0;
      strbQ   <= '0;
      wdataQ  <= '0;
      writeQ  <= 1'b0;
      isReadQ <= 1'b0;
    end else if (setupPhase) begin
      idxQ    <= index;
      strbQ   <= iPstrb;
      wdataQ  <= iPwdata;
      writeQ  <= iPwrite;
      isReadQ <= ~iPwrite;
    end
  end

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (setupPhase) begin
          if (!addrOk)                            nextState = ERROR;
          else if (!iPwrite || fullStrb || nullStrb) nextState = ACCESS;
          else                                    nextState = MERGE;
        end
      end
      MERGE:   nextState = (iPsel && iPenable) ? ACCESS : IDLE;
      ACCESS:  nextState = IDLE;
      ERROR:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs are gated by iRsn so the SRAM sees oCsn=1 from the reset edge on.
  always_comb begin
    oCsn     = 1'b1;
    oWrn     = 1'b1;
    oAddr    = '0;
    oWrDt    = '0;
    oPready  = 1'b0;
    oPslverr = 1'b0;
    oPrdata  = '0;
    if (iRsn) begin
      case (state)
        IDLE: begin
          if (setupPhase && addrOk) begin
            if (!iPwrite) begin
              oCsn  = 1'b0;
              oAddr = index;
            end else if (fullStrb) begin
              oCsn  = 1'b0;
              oWrn  = 1'b0;
              oAddr = index;
              oWrDt = iPwdata;
            end else if (!nullStrb) begin
              oCsn  = 1'b0;
              oAddr = index;
            end
          end
        end
        MERGE: begin
          if (iPsel && iPenable && writeQ) begin
            oCsn  = 1'b0;
            oWrn  = 1'b0;
            oAddr = idxQ;
            oWrDt = mergedDt;
          end
        end
        ACCESS: begin
          oPready = 1'b1;
          oPrdata = isReadQ ? iRdDt : 32'h0;
        end
        ERROR: begin
          oPready  = 1'b1;
          oPslverr = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_sram_ctrl.sv
// Directed bench for apb_sram_ctrl with a behavioural SRAM and a completion
// scoreboard fed by the driver and drained by a negedge monitor.
module tb_apb_sram_ctrl;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } expT;

  logic        iClk = 1'b0;
  logic        iRsn;
  logic        iPsel, iPenable, iPwrite;
  logic [7:0]  iPaddr;
  logic [31:0] iPwdata;
  logic [3:0]  iPstrb;
  logic [31:0] oPrdata;
  logic        oPready, oPslverr, oCsn, oWrn;
  logic [3:0]  oAddr;
  logic [31:0] oWrDt;
  logic [31:0] iRdDt;

  logic [31:0] mem [16];
  logic [3:0]  lastWrAddr;
  int          wrStrobes;
  int          anyStrobes;

  expT         expQ[$];
  int          assertCount = 0;
  int          failCount   = 0;
  int          waitCount   = 0;

  always #5 iClk = ~iClk;

  apb_sram_ctrl #(.P_AW(8), .P_MAW(4)) dut (
    .iClk     (iClk),
    .iRsn     (iRsn),
    .iPsel    (iPsel),
    .iPenable (iPenable),
    .iPwrite  (iPwrite),
    .iPaddr   (iPaddr),
    .iPwdata  (iPwdata),
    .iPstrb   (iPstrb),
    .oPrdata  (oPrdata),
    .oPready  (oPready),
    .oPslverr (oPslverr),
    .oCsn     (oCsn),
    .oWrn     (oWrn),
    .oAddr    (oAddr),
    .oWrDt    (oWrDt),
    .iRdDt    (iRdDt)
  );

  // Behavioural SRAM macro: read data appears one cycle after the strobe.
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    iRdDt      = 32'h0;
    wrStrobes  = 0;
    anyStrobes = 0;
    lastWrAddr = 4'h0;
  end

  always @(posedge iClk) begin
    if (!oCsn) begin
      anyStrobes <= anyStrobes + 1;
      if (!oWrn) begin
        mem[oAddr] <= oWrDt;
        wrStrobes  <= wrStrobes + 1;
        lastWrAddr <= oAddr;
      end else begin
        iRdDt <= mem[oAddr];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: counts wait states and scores each completed transfer.
  always @(negedge iClk) begin
    if (!iRsn) begin
      waitCount = 0;
    end else if (iPsel && iPenable) begin
      if (!oPready) begin
        waitCount++;
      end else if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpected completion: got rdata 0x%08h, expected none", oPrdata);
      end else begin
        expT e;
        e = expQ.pop_front();
        checkOutput({e.name, " rdata"}, oPrdata, e.rdata);
        checkOutput({e.name, " slverr"}, {31'h0, oPslverr}, {31'h0, e.err});
        checkOutput({e.name, " waits"}, waitCount, e.waits);
        waitCount = 0;
      end
    end
  end

  task automatic applyStimulus(input string name, input logic wr, input logic [7:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb,
                               input logic [31:0] expRd, input logic expErr, input int expWaits);
    bit done;
    expQ.push_back('{name, expRd, expErr, expWaits});
    iPsel    = 1'b1;
    iPenable = 1'b0;
    iPwrite  = wr;
    iPaddr   = addr;
    iPwdata  = wdata;
    iPstrb   = strb;
    @(posedge iClk);
    #1 iPenable = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge iClk);
      if (oPready) done = 1'b1;
    end
    if (!done) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL %s timeout: got no PREADY in 20 cycles, expected completion", name);
      if (expQ.size() > 0) void'(expQ.pop_front());
    end
    @(posedge iClk);
    #1;
    iPsel    = 1'b0;
    iPenable = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " oCsn"},     {31'h0, oCsn},     32'h1);
    checkOutput({tag, " oWrn"},     {31'h0, oWrn},     32'h1);
    checkOutput({tag, " oAddr"},    {28'h0, oAddr},    32'h0);
    checkOutput({tag, " oWrDt"},    oWrDt,             32'h0);
    checkOutput({tag, " oPready"},  {31'h0, oPready},  32'h0);
    checkOutput({tag, " oPslverr"}, {31'h0, oPslverr}, 32'h0);
    checkOutput({tag, " oPrdata"},  oPrdata,           32'h0);
  endtask

  initial begin
    int strobesBefore;
    int writesBefore;

    // Reset with an active read setup on the bus: outputs must stay forced.
    iRsn     = 1'b0;
    iPsel    = 1'b1;
    iPenable = 1'b0;
    iPwrite  = 1'b0;
    iPaddr   = 8'h14;
    iPwdata  = 32'h0;
    iPstrb   = 4'hF;
    #22;
    checkResetOutputs("reset");
    iPsel = 1'b0;
    @(posedge iClk);
    #1 iRsn = 1'b1;
    @(posedge iClk);
    #1;

    applyStimulus("full write 0x14", 1'b1, 8'h14, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0);
    checkOutput("full write strobes", wrStrobes, 1);
    checkOutput("full write word", {28'h0, lastWrAddr}, 32'h5);
    applyStimulus("read 0x14", 1'b0, 8'h14, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0);

    applyStimulus("partial write 0x14", 1'b1, 8'h14, 32'h11223344, 4'b0101, 32'h0, 1'b0, 1);
    checkOutput("partial write strobes", wrStrobes, 2);
    applyStimulus("read merged 0x14", 1'b0, 8'h14, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, 0);

    strobesBefore = anyStrobes;
    applyStimulus("error read 0x40", 1'b0, 8'h40, 32'h0, 4'h0, 32'h0, 1'b1, 0);
    applyStimulus("error write 0x06", 1'b1, 8'h06, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1, 0);
    checkOutput("error no strobe", anyStrobes, strobesBefore);
    applyStimulus("read 0x04 after error", 1'b0, 8'h04, 32'h0, 4'h0, 32'h0, 1'b0, 0);

    strobesBefore = anyStrobes;
    applyStimulus("null write 0x00", 1'b1, 8'h00, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 0);
    checkOutput("null write no strobe", anyStrobes, strobesBefore);
    applyStimulus("read 0x00", 1'b0, 8'h00, 32'h0, 4'h0, 32'h0, 1'b0, 0);

    applyStimulus("b2b write 0x3C", 1'b1, 8'h3C, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0, 0);
    applyStimulus("b2b read 0x3C", 1'b0, 8'h3C, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0, 0);

    // Reset lands in the MERGE cycle while the merged write is being driven.
    writesBefore = wrStrobes;
    iPsel    = 1'b1;
    iPenable = 1'b0;
    iPwrite  = 1'b1;
    iPaddr   = 8'h14;
    iPwdata  = 32'h000000FF;
    iPstrb   = 4'b0001;
    @(posedge iClk);
    #1 iPenable = 1'b1;
    #1;
    checkOutput("merge write pending", {31'h0, oCsn}, 32'h0);
    iRsn = 1'b0;
    #1;
    checkOutput("reset in merge oCsn", {31'h0, oCsn}, 32'h1);
    iPsel    = 1'b0;
    iPenable = 1'b0;
    @(posedge iClk);
    #1;
    checkOutput("reset in merge no write", wrStrobes, writesBefore);
    checkResetOutputs("reset in merge");
    iRsn = 1'b1;
    @(posedge iClk);
    #1;
    checkResetOutputs("after release");
    applyStimulus("read 0x14 after reset", 1'b0, 8'h14, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, 0);

    repeat (2) @(posedge iClk);
    checkOutput("scoreboard drained", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
